// File: rtl/exec_pkg.sv
// Shared encodings for the LC-3b execute stage: opcodes, FSM states,
// shift-control bit positions and the condition-code reset value.
package exec_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_SHF = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_WB    = 2'd2
    } state_e;

    // IR[5:4]: bit0 alone picks direction, so 2'b10 is still a left shift.
    localparam int SHF_RIGHT_BIT = 0;
    localparam int SHF_ARITH_BIT = 1;

    localparam logic [2:0] NZP_RST = 3'b010;

endpackage

// File: rtl/exec_unit_iter_shifter.sv
// One-bit-per-cycle shifter: a WIDTH-bit value register and a down-counter
// whose 'last' flag marks the step that produces the final value.
module iter_shifter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             right,
    input  logic             arith,
    input  logic [WIDTH-1:0] load_val,
    input  logic [CNT_W-1:0] load_cnt,
    output logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] value_nxt,
    output logic             last
);

    logic [WIDTH-1:0] value_q;
    logic [CNT_W-1:0] cnt_q;

    // Result of one step; exposed so the owner can derive flags for the final value.
    assign value_nxt = right ? {arith & value_q[WIDTH-1], value_q[WIDTH-1:1]}
                             : {value_q[WIDTH-2:0], 1'b0};
    assign value     = value_q;
    assign last      = (cnt_q == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            value_q <= load_val;
            cnt_q   <= load_cnt;
        end else if (step) begin
            value_q <= value_nxt;
            cnt_q   <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/exec_unit.sv
// LC-3b execute stage: single-cycle ADD/AND/XOR, iterative shifts, and a
// one-cycle write-back pulse carrying result, destination and NZP.
module exec_unit
    import exec_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             steer,
    input  logic [4:0]       imm5,
    input  logic [1:0]       shf_ctl,
    input  logic [CNT_W-1:0] amount,
    input  logic [2:0]       dr_in,
    input  logic [WIDTH-1:0] RA,
    input  logic [WIDTH-1:0] RB,
    output logic [WIDTH-1:0] bus,
    output logic             WE,
    output logic [2:0]       DR,
    output logic [2:0]       nzp,
    output logic             busy
);

    state_e           state_q;
    logic             we_q, busy_q, right_q, arith_q;
    logic [2:0]       dr_q, DR_q, nzp_q;
    logic [WIDTH-1:0] b_opnd, alu_res, load_val, sh_val, sh_nxt;
    logic [CNT_W-1:0] load_cnt;
    logic             is_shf, accept, step, sh_last;

    function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1])    return 3'b100;
        else if (v == '0)  return 3'b010;
        else               return 3'b001;
    endfunction

    assign b_opnd = steer ? {{(WIDTH-5){imm5[4]}}, imm5} : RB;

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = RA + b_opnd;
            OP_AND:  alu_res = RA & b_opnd;
            OP_XOR:  alu_res = RA ^ b_opnd;
            default: alu_res = RA;
        endcase
    end

    assign is_shf   = (op == OP_SHF);
    assign accept   = (state_q == S_IDLE) && start;
    assign step     = (state_q == S_SHIFT);
    // ALU results go through the shifter register too, so it alone owns bus.
    assign load_val = is_shf ? RA : alu_res;
    assign load_cnt = is_shf ? amount : '0;

    iter_shifter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_shf (
        .clk       (clk),
        .rst_n     (reset),
        .load      (accept),
        .step      (step),
        .right     (right_q),
        .arith     (arith_q),
        .load_val  (load_val),
        .load_cnt  (load_cnt),
        .value     (sh_val),
        .value_nxt (sh_nxt),
        .last      (sh_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            right_q <= 1'b0;
            arith_q <= 1'b0;
            dr_q    <= '0;
            DR_q    <= '0;
            nzp_q   <= NZP_RST;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    dr_q    <= dr_in;
                    right_q <= shf_ctl[SHF_RIGHT_BIT];
                    arith_q <= shf_ctl[SHF_ARITH_BIT];
                    busy_q  <= 1'b1;
                    if (is_shf && amount != '0) begin
                        state_q <= S_SHIFT;
                    end else begin
                        state_q <= S_WB;
                        we_q    <= 1'b1;
                        DR_q    <= dr_in;
                        nzp_q   <= nzp_of(load_val);
                    end
                end
                S_SHIFT: if (sh_last) begin
                    state_q <= S_WB;
                    we_q    <= 1'b1;
                    DR_q    <= dr_q;
                    nzp_q   <= nzp_of(sh_nxt);
                end
                S_WB: begin
                    state_q <= S_IDLE;
                    we_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus  = sh_val;
    assign WE   = we_q;
    assign DR   = DR_q;
    assign nzp  = nzp_q;
    assign busy = busy_q;

endmodule
